// File: rtl/fdtd_calc_hy_if.sv
// Sample/result stream for the Hy line-update block: Ez/Hy_old samples in,
// updated Hy results out.
interface fdtd_calc_hy_if #(
    parameter int W = 32
) ();
    logic                valid_i;
    logic                ready_o;
    logic signed [W-1:0] Ez_old_i;
    logic signed [W-1:0] Hy_old_i;
    logic signed [W-1:0] Hy_n_o;
    logic                valid_o;
    logic                last_o;

    modport master (
        output valid_i, Ez_old_i, Hy_old_i,
        input  ready_o, Hy_n_o, valid_o, last_o
    );

    modport slave (
        input  valid_i, Ez_old_i, Hy_old_i,
        output ready_o, Hy_n_o, valid_o, last_o
    );
endinterface

// File: rtl/fdtd_calc_hy.sv
// FDTD Hy line update: Hy[i] = cut(chyh*Hy_old[i]) + cut(chyez*(Ez[i+1]-Ez[i])),
// Ez[N] = 0, streamed one cell per cycle through a 4-stage pipeline.
module fdtd_calc_hy #(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int CUT_LT          = 51,
    parameter int CUT_RT          = 21,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              clken,
    input  logic                              start_i,
    input  logic [CNT_WIDTH-1:0]              cell_num_i,
    input  logic signed [FDTD_DATA_WIDTH-1:0] chyh,
    input  logic signed [FDTD_DATA_WIDTH-1:0] chyez,
    output logic                              busy_o,
    output logic                              done_o,
    fdtd_calc_hy_if.slave                     s
);
    localparam int W      = FDTD_DATA_WIDTH;
    localparam int STAGES = 3;

    typedef enum logic [2:0] {IDLE, FIRST, RUN, FLUSH, DRAIN} state_e;

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   n_q, n_d, cnt_q, cnt_d;
    logic signed [W-1:0]    ez_prev_q, hy_prev_q;
    logic                   ready;
    logic                   store, issue, issue_last;
    logic signed [W-1:0]    issue_ez_nxt;
    logic                   done_q, done_d;

    logic [STAGES:0]        vld_pipe_q, last_pipe_q;
    logic signed [W-1:0]    iss_ezc_q, iss_ezn_q, iss_hy_q;
    logic signed [W-1:0]    diff_q, hy2_q, hy_n_q;
    logic signed [2*W-1:0]  ph_q, pe_q;

    function automatic logic signed [2*W-1:0] sext(input logic signed [W-1:0] a);
        return {{W{a[W-1]}}, a};
    endfunction

    // Keep the product sign plus the bit window that realigns the fixed point.
    function automatic logic signed [W-1:0] cut(input logic signed [2*W-1:0] p);
        return {p[2*W-1], p[CUT_LT:CUT_RT]};
    endfunction

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        cnt_d        = cnt_q;
        ready        = 1'b0;
        store        = 1'b0;
        issue        = 1'b0;
        issue_last   = 1'b0;
        issue_ez_nxt = s.Ez_old_i;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && cell_num_i != '0) begin
                    state_d = FIRST;
                    n_d     = cell_num_i;
                    cnt_d   = '0;
                end
            end
            FIRST: begin
                ready = 1'b1;
                if (s.valid_i) begin
                    store   = 1'b1;
                    cnt_d   = CNT_WIDTH'(1);
                    state_d = (n_q == CNT_WIDTH'(1)) ? FLUSH : RUN;
                end
            end
            RUN: begin
                ready = 1'b1;
                // A new Ez[j] completes the stencil of the stored cell j-1.
                if (s.valid_i) begin
                    store = 1'b1;
                    issue = 1'b1;
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == n_q - CNT_WIDTH'(1)) state_d = FLUSH;
                end
            end
            FLUSH: begin
                issue        = 1'b1;
                issue_last   = 1'b1;
                issue_ez_nxt = '0;
                state_d      = DRAIN;
            end
            DRAIN: begin
                if (vld_pipe_q[STAGES] && last_pipe_q[STAGES]) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            n_q         <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            ez_prev_q   <= '0;
            hy_prev_q   <= '0;
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            iss_ezc_q   <= '0;
            iss_ezn_q   <= '0;
            iss_hy_q    <= '0;
            diff_q      <= '0;
            hy2_q       <= '0;
            ph_q        <= '0;
            pe_q        <= '0;
            hy_n_q      <= '0;
        end else if (clken) begin
            state_q     <= state_d;
            n_q         <= n_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], issue};
            last_pipe_q <= {last_pipe_q[STAGES-1:0], issue_last};
            if (store) begin
                ez_prev_q <= s.Ez_old_i;
                hy_prev_q <= s.Hy_old_i;
            end
            if (issue) begin
                iss_ezc_q <= ez_prev_q;
                iss_ezn_q <= issue_ez_nxt;
                iss_hy_q  <= hy_prev_q;
            end
            diff_q <= iss_ezn_q - iss_ezc_q;
            hy2_q  <= iss_hy_q;
            ph_q   <= sext(chyh) * sext(hy2_q);
            pe_q   <= sext(chyez) * sext(diff_q);
            hy_n_q <= cut(ph_q) + cut(pe_q);
        end
    end

    // Product bits outside the kept window are intentionally dropped.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{ph_q[2*W-2:CUT_LT+1], ph_q[CUT_RT-1:0],
                                pe_q[2*W-2:CUT_LT+1], pe_q[CUT_RT-1:0]};

    assign s.ready_o = ready;
    assign s.Hy_n_o  = hy_n_q;
    assign s.valid_o = vld_pipe_q[STAGES];
    assign s.last_o  = last_pipe_q[STAGES];
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
endmodule

// File: tb/tb_fdtd_calc_hy.sv
// Bench for fdtd_calc_hy: table of line updates with constant expected results,
// scoreboard queue checked by a monitor, plus reset/start corner sequences.
module tb_fdtd_calc_hy;
    localparam int W    = 32;
    localparam int CW   = 16;
    localparam int MAXC = 4;

    logic          CLK = 1'b0, RST_N = 1'b0, clken = 1'b1, start_i = 1'b0;
    logic [CW-1:0] cell_num_i = '0;
    logic [W-1:0]  chyh = '0, chyez = '0;
    logic          busy_o, done_o;

    fdtd_calc_hy_if #(.W(W)) s ();

    fdtd_calc_hy #(.FDTD_DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST_N(RST_N), .clken(clken), .start_i(start_i),
        .cell_num_i(cell_num_i), .chyh(chyh), .chyez(chyez),
        .busy_o(busy_o), .done_o(done_o), .s(s)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int                        n;
        logic [W-1:0]              ch, ce;
        logic [MAXC-1:0][W-1:0]    ez, hy, ex;
        int                        gap, coff, sbusy, abort;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] v;
        logic         last;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    vec_t  vt[$];
    int    vectors = 0, miscompares = 0;
    int    en_cnt = 0;
    logic  clken_edge = 1'b0;
    logic  last_seen = 1'b0;

    function automatic vec_t mk(int n, logic [W-1:0] ch, ce,
                                logic [W-1:0] e0, e1, e2, e3,
                                logic [W-1:0] h0, h1, h2, h3,
                                logic [W-1:0] x0, x1, x2, x3,
                                int gap = 0, int coff = -1, int sbusy = -1, int abort = -1);
        vec_t v;
        v.n = n; v.ch = ch; v.ce = ce;
        v.ez[0] = e0; v.ez[1] = e1; v.ez[2] = e2; v.ez[3] = e3;
        v.hy[0] = h0; v.hy[1] = h1; v.hy[2] = h2; v.hy[3] = h3;
        v.ex[0] = x0; v.ex[1] = x1; v.ex[2] = x2; v.ex[3] = x3;
        v.gap = gap; v.coff = coff; v.sbusy = sbusy; v.abort = abort;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_hy_n"},  s.Hy_n_o, '0);
        chk({name, "_valid"}, W'(s.valid_o), '0);
        chk({name, "_last"},  W'(s.last_o), '0);
        chk({name, "_busy"},  W'(busy_o), '0);
        chk({name, "_ready"}, W'(s.ready_o), '0);
        chk({name, "_done"},  W'(done_o), '0);
    endtask

    always @(posedge CLK) begin
        clken_edge <= clken;
        if (clken) en_cnt <= en_cnt + 1;
    end

    // Monitor: one check per produced result, plus done timing each enabled cycle.
    always @(negedge CLK) begin
        if (!RST_N) begin
            last_seen = 1'b0;
        end else if (clken_edge) begin
            if (s.valid_o) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_valid: got Hy_n_o=%h, expected no output (t=%0t)", s.Hy_n_o, $time);
                end else begin
                    e = sb.pop_front();
                    chk("hy_n", s.Hy_n_o, e.v);
                    chk("last", W'(s.last_o), W'(e.last));
                end
            end
            chk("done", W'(done_o), W'(last_seen));
            last_seen = s.valid_o & s.last_o;
        end
    end

    task automatic run_line(input vec_t v);
        int s0, g;
        bit x;
        chyh = v.ch; chyez = v.ce; cell_num_i = CW'(v.n); start_i = 1'b1;
        s0 = en_cnt;
        for (int i = 0; i < v.n && i < MAXC; i++)
            sb.push_back({v.ex[i], (i == v.n - 1)});
        @(negedge CLK);
        start_i = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            s.valid_i = 1'b1;
            s.Ez_old_i = v.ez[i % MAXC];
            s.Hy_old_i = v.hy[i % MAXC];
            if (i == v.sbusy) begin start_i = 1'b1; cell_num_i = CW'(7); end
            g = 0;
            do begin
                x = s.ready_o && clken;
                @(negedge CLK);
                g++;
            end while (!x && g < 50);
            start_i = 1'b0;
            s.valid_i = 1'b0;
            if (!x) begin
                vectors++;
                miscompares++;
                $display("FAIL xfer_timeout: cell %0d not accepted, expected transfer within 50 cycles", i);
                return;
            end
            if (i == v.abort) begin
                RST_N = 1'b0;
                sb.delete();
                #1 check_idle("rst_mid");
                @(negedge CLK);
                RST_N = 1'b1;
                return;
            end
            if (i == v.coff) begin
                clken = 1'b0;
                repeat (3) @(negedge CLK);
                clken = 1'b1;
            end
            repeat (v.gap) @(negedge CLK);
        end
        g = 0;
        while (!(done_o && clken_edge) && g < 100) begin
            @(negedge CLK);
            g++;
        end
        if (g >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done_o, expected one within 100 cycles");
        end else if (v.gap == 0 && v.coff < 0) begin
            chk("line_cycles", W'(en_cnt - s0 - 1), W'(v.n + 5));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        s.valid_i = 1'b0; s.Ez_old_i = '0; s.Hy_old_i = '0;
        vt.push_back(mk(3, 32'h200000, 32'h200000, 10, 30, 70, 0, 5, 5, 5, 0, 25, 45, -65, 0));
        vt.push_back(mk(1, 32'h200000, 32'h100000, 8, 0, 0, 0, 3, 0, 0, 0, -1, 0, 0, 0));
        vt.push_back(mk(3, 32'h200000, 32'h200000, 10, 30, 70, 0, 5, 5, 5, 0, 25, 45, -65, 0, 2, 1));
        vt.push_back(mk(2, 32'h200000, 32'h0, 1, 2, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0,
                        32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0));
        vt.push_back(mk(2, 32'h0, 32'h200000, 32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 0, 0, 0,
                        32'hFFFFFFFF, 32'h80000001, 0, 0));
        vt.push_back(mk(2, 32'h200000, 32'h200000, 0, 1, 0, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0,
                        32'h80000000, 32'h7FFFFFFE, 0, 0));
        vt.push_back(mk(2, 32'h100000, 32'h300000, 100, -20, 0, 0, -7, 40, 0, 0, -184, 50, 0, 0));
        vt.push_back(mk(4, 32'h200000, 32'h200000, 1, 2, 4, 8, 0, 0, 0, 0, 1, 2, 4, -8, 0, -1, 2));

        repeat (2) @(negedge CLK);
        check_idle("reset");
        RST_N = 1'b1;
        @(negedge CLK);

        foreach (vt[i]) run_line(vt[i]);

        // Reset in the middle of a long line, then a fresh short line.
        run_line(mk(10, 32'h200000, 32'h200000, 3, 6, 9, 12, 1, 1, 1, 1, 0, 0, 0, 0, 0, -1, -1, 2));
        repeat (10) @(negedge CLK);
        chk("post_rst_busy", W'(busy_o), '0);
        run_line(vt[6]);

        // A zero-length start must be ignored.
        cell_num_i = '0;
        start_i = 1'b1;
        @(negedge CLK);
        start_i = 1'b0;
        chk("n0_busy", W'(busy_o), '0);
        chk("n0_ready", W'(s.ready_o), '0);
        repeat (8) @(negedge CLK);
        chk("n0_busy_later", W'(busy_o), '0);
        chk("sb_empty", W'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fdtd_calc_hy.md
FDTD_CALC_HY -- requirements
Module: fdtd_calc_hy

Interface
REQ-001 SHALL have parameter FDTD_DATA_WIDTH, default 32: width of field samples, coefficients and result.
REQ-002 SHALL have parameter CUT_LT, default 51: upper product bit kept after scaling.
REQ-003 SHALL have parameter CUT_RT, default 21: lower product bit kept; coefficient 1.0 = 2^CUT_RT.
REQ-004 SHALL have parameter CNT_WIDTH, default 16: width of the cell counter.
REQ-005 CLK  input  1  sole clock, rising edge.
REQ-006 RST_N  input  1  asynchronous active-low reset.
REQ-007 clken  input  1  global pipeline enable; low freezes all state.
REQ-008 start_i  input  1  one-cycle pulse that begins one line update.
REQ-009 cell_num_i  input  CNT_WIDTH  number of cells N in the line; sampled on accepted start.
REQ-010 valid_i  input  1  Ez_old_i/Hy_old_i hold cell i data.
REQ-011 ready_o  output  1  block accepts a sample this cycle.
REQ-012 Ez_old_i, Hy_old_i  input  FDTD_DATA_WIDTH signed  Ez[i], Hy_old[i], presented in increasing i.
REQ-013 chyh, chyez  input  FDTD_DATA_WIDTH signed  material coefficients; static during a line.
REQ-014 Hy_n_o  output  FDTD_DATA_WIDTH signed  updated Hy[i].
REQ-015 valid_o  output  1  Hy_n_o valid; one pulse per cell.
REQ-016 last_o  output  1  high with valid_o for cell N-1.
REQ-017 busy_o, done_o  output  1 each  line in progress; one-cycle pulse after last result.

Function
REQ-018 Result SHALL be Hy[i] = cut(chyh*Hy_old[i]) + cut(chyez*(Ez[i+1]-Ez[i])), with Ez[N] = 0 (boundary).
REQ-019 cut(p) SHALL be {p[2W-1], p[CUT_LT:CUT_RT]}; subtraction, full 2W-bit products and final add SHALL wrap two's-complement mod 2^W, no saturation.
REQ-020 Sample transfer SHALL occur on a rising edge with clken & valid_i & ready_o all high; otherwise inputs are ignored.
REQ-021 With clken low, every register, counter, state and output SHALL hold; outputs keep their value (valid_o/done_o do not re-pulse).
REQ-022 FSM states: IDLE, FIRST, RUN, FLUSH, DRAIN.
REQ-023 IDLE: ready_o=0, busy_o=0; start_i with clken and cell_num_i!=0 -> FIRST; start_i with cell_num_i=0 ignored.
REQ-024 FIRST: ready_o=1; on transfer store Ez[0], Hy_old[0]; -> RUN if N>1, else FLUSH.
REQ-025 RUN: ready_o=1; each transfer of cell j issues computation of cell j-1 from stored pair and new Ez[j], then stores cell j; after transfer of cell N-1 -> FLUSH.
REQ-026 FLUSH: ready_o=0; on one clken cycle inject Ez=0 to compute cell N-1; -> DRAIN.
REQ-027 DRAIN: ready_o=0; when cell N-1 result leaves pipeline assert done_o one cycle -> IDLE.
REQ-028 Pipeline: issue register, difference/Hy-align stage, multiply stage, cut+add output stage; valid_o SHALL rise exactly 3 enabled edges after the issuing edge (transfer or flush).
REQ-029 busy_o SHALL be high in all states except IDLE; start_i while busy SHALL be ignored.
REQ-030 Back-to-back: with valid_i held high and clken=1, one result per cycle; a line of N cells completes in N+5 enabled cycles from start.
REQ-031 done_o SHALL assert the cycle after valid_o&last_o; a new start_i accepted in that IDLE cycle SHALL be legal.

Reset
REQ-032 RST_N low SHALL asynchronously force IDLE, zero all pipeline registers and counters, Hy_n_o=0, valid_o=0, last_o=0, done_o=0, busy_o=0, ready_o=0.
REQ-033 Reset mid-line SHALL discard the line; no valid_o or done_o SHALL follow release until a new start.

Verification
REQ-034 chyh=chyez=0x200000, N=3, Ez={10,30,70}, Hy_old={5,5,5}, continuous -> Hy_n_o 25, 45, -65; last_o with -65; done_o next cycle.
REQ-035 N=1, Ez={8}, Hy_old={3}, chyh=0x200000, chyez=0x100000 -> single result 3+(-4)=-1 with valid_o & last_o.
REQ-036 Same as REQ-034 with valid_i deasserted 2 cycles between samples and clken low 3 cycles mid-pipe -> identical values and order, no duplicate/lost pulses.
REQ-037 chyh=0x200000, chyez=0, Hy_old=0x7FFFFFFF, N=2 -> wrap check: result 0x7FFFFFFF; chyez=0x200000, Ez={0x80000000,0x7FFFFFFF... } -> difference wraps mod 2^32 per REQ-019.
REQ-038 Assert RST_N during RUN of N=10 line, release, start N=2 -> only 2 valid_o pulses, correct values; start_i during busy and start with N=0 produce no activity.
